// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared types, states and wide-op decode for the ALU sequencer
package alu_sequencer_pkg;

  localparam int OPC_W  = 10;
  localparam int DATA_W = 64;
  localparam int RES_W  = 128;
  localparam int TO_W   = 8;

  typedef logic [OPC_W-1:0] opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WB_LO = 3'd3,
    WB_HI = 3'd4
  } alu_seq_state_t;

  // Multiply-class extensions return a full 128-bit product.
  localparam opcode_t WIDE_OPS [2] = '{10'h3A4, 10'h3A5};

  function automatic logic is_wide_op(input opcode_t opc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (opc == WIDE_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// rtl/alu_seq_timeout.sv - loadable down-counter bounding the wait for ALU completion
module alu_seq_timeout
  import alu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TO_W'(TIMEOUT);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reaches zero after TIMEOUT ticks following a clear.
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - execute-stage ALU sequencer with timeout and retired counter
// ALU_SEQ_WIDE_WB_EN defined: wide ops write back in two 64-bit beats (WB_LO then WB_HI).
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DST_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0]  in_oprd1,
  input  logic [DATA_W-1:0]  in_oprd2,
  input  logic [DATA_W-1:0]  in_oprd3,
  input  logic [DST_W-1:0]   in_dst,
  output logic               alu_enable,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0]  alu_oprd1,
  output logic [DATA_W-1:0]  alu_oprd2,
  output logic [DATA_W-1:0]  alu_oprd3,
  input  logic [RES_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]  alu_flags,
  input  logic               alu_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DST_W-1:0]   wb_dst,
  output logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  wb_flags,
  output logic               wb_last,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   retired
);

  alu_seq_state_t state_q, state_d;

  opcode_t           opcode_q;
  logic [DATA_W-1:0] oprd1_q, oprd2_q, oprd3_q;
  logic [DST_W-1:0]  dst_q;
  logic [DATA_W-1:0] res_lo_q;
  logic [DATA_W-1:0] flags_q;
  logic [CNT_W-1:0]  retired_q;

  logic accept, capture, retire;
  logic to_clear, to_tick, to_expired;

`ifdef ALU_SEQ_WIDE_WB_EN
  logic              wide_q;
  logic [DATA_W-1:0] res_hi_q;
`else
  logic unused_res_hi;
  assign unused_res_hi = ^alu_result[RES_W-1:DATA_W];
`endif

  alu_seq_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .tick   (to_tick),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    to_clear    = 1'b0;
    to_tick     = 1'b0;
    in_ready    = 1'b0;
    alu_enable  = 1'b0;
    alu_opcode  = '0;
    alu_oprd1   = '0;
    alu_oprd2   = '0;
    alu_oprd3   = '0;
    wb_valid    = 1'b0;
    wb_dst      = '0;
    wb_data     = '0;
    wb_flags    = '0;
    wb_last     = 1'b0;
    err_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        alu_enable = 1'b1;
        alu_opcode = opcode_q;
        alu_oprd1  = oprd1_q;
        alu_oprd2  = oprd2_q;
        alu_oprd3  = oprd3_q;
        to_clear   = 1'b1;
        state_d    = WAIT;
      end

      WAIT: begin
        alu_opcode = opcode_q;
        alu_oprd1  = oprd1_q;
        alu_oprd2  = oprd2_q;
        alu_oprd3  = oprd3_q;
        // Completion takes priority over a timeout landing in the same cycle.
        if (alu_done) begin
          capture = 1'b1;
          state_d = WB_LO;
        end else if (to_expired) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          to_tick = 1'b1;
        end
      end

      WB_LO: begin
        wb_valid = 1'b1;
        wb_dst   = dst_q;
        wb_data  = res_lo_q;
        wb_flags = flags_q;
`ifdef ALU_SEQ_WIDE_WB_EN
        wb_last  = !wide_q;
        if (wb_ready) begin
          if (wide_q) begin
            state_d = WB_HI;
          end else begin
            retire  = 1'b1;
            state_d = IDLE;
          end
        end
`else
        wb_last  = 1'b1;
        if (wb_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
`endif
      end

`ifdef ALU_SEQ_WIDE_WB_EN
      WB_HI: begin
        wb_valid = 1'b1;
        wb_dst   = dst_q;
        wb_data  = res_hi_q;
        wb_flags = flags_q;
        wb_last  = 1'b1;
        if (wb_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q  <= '0;
      oprd1_q   <= '0;
      oprd2_q   <= '0;
      oprd3_q   <= '0;
      dst_q     <= '0;
      res_lo_q  <= '0;
      flags_q   <= '0;
      retired_q <= '0;
`ifdef ALU_SEQ_WIDE_WB_EN
      wide_q    <= 1'b0;
      res_hi_q  <= '0;
`endif
    end else begin
      if (accept) begin
        opcode_q <= in_opcode;
        oprd1_q  <= in_oprd1;
        oprd2_q  <= in_oprd2;
        oprd3_q  <= in_oprd3;
        dst_q    <= in_dst;
`ifdef ALU_SEQ_WIDE_WB_EN
        wide_q   <= is_wide_op(in_opcode);
`endif
      end
      if (capture) begin
        res_lo_q <= alu_result[DATA_W-1:0];
        flags_q  <= alu_flags;
`ifdef ALU_SEQ_WIDE_WB_EN
        res_hi_q <= alu_result[RES_W-1:DATA_W];
`endif
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign retired = retired_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage controller that sequences the shared ALU. It accepts one decoded operation at a time from decode through a valid/ready handshake and drives the ALU's enable, opcode and operands for exactly one cycle. It waits for the ALU's completion pulse and captures the 128-bit result and flags, then hands the result to the memory/writeback stage in one or two 64-bit beats. It also owns a completion timeout and a retired-op counter.

## Interface
Parameters:
- DST_W, 4: destination register index width
- TIMEOUT, 15: max cycles in WAIT before abort (1..255)
- CNT_W, 32: retired-op counter width

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an op
- in_ready  out  1  sequencer can accept
- in_opcode  in  10  opcode_t
- in_oprd1/in_oprd2/in_oprd3  in  64 each  operands
- in_dst  in  DST_W  destination register index
- alu_enable  out  1  ALU enable
- alu_opcode  out  10  to ALU opcode
- alu_oprd1/alu_oprd2/alu_oprd3  out  64 each  to ALU operands
- alu_result  in  128  ALU result
- alu_flags  in  64  ALU flags
- alu_done  in  1  ALU completion pulse (its exe_mem output)
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  downstream accepts beat
- wb_dst  out  DST_W  destination index
- wb_data  out  64  beat data
- wb_flags  out  64  captured flags (valid on every beat)
- wb_last  out  1  final beat of op
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle abort pulse
- retired  out  CNT_W  ops fully written back

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB_LO, WB_HI.
- IDLE: in_ready=1. On in_valid: capture opcode, operands, dst, wide = is_wide_op(opcode). Go to ISSUE.
- ISSUE: alu_enable=1 for exactly this cycle; alu_* driven from captured regs. Go to WAIT and clear the timeout counter.
- WAIT: alu_* held and alu_enable=0.
  - On alu_done: capture alu_result and alu_flags, go to WB_LO.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: pulse err_timeout, drop the op with no writeback and no count, go to IDLE.
- WB_LO: wb_valid=1, wb_data=result[63:0], wb_last=!wide. On wb_ready: go to WB_HI if wide, else go to IDLE and increment retired.
- WB_HI: wb_valid=1, wb_data=result[127:64], wb_last=1. On wb_ready: go to IDLE and increment retired.
- alu_done outside WAIT is ignored; no state change.
- wb_valid stays high and wb_data, wb_dst, wb_flags, wb_last stay stable until wb_ready.
- retired wraps modulo 2^CNT_W.
- in_ready is 0 in every state except IDLE. There is no back-to-back overlap.

## Timing
- Reset (sync): state=IDLE. in_ready=1 from the first cycle after reset. All other outputs 0, including alu_enable, wb_valid, err_timeout, retired, busy, alu_* and wb_*.
- Reset mid-operation discards any in-flight op. The next cycle is IDLE and no wb beat is issued.
- Handshake at edge N (in_valid&&in_ready): ISSUE in cycle N+1, WAIT from N+2. With alu_done at N+2, wb_valid is first visible at N+3.
- Minimum accept-to-accept spacing with wb_ready=1: 4 cycles for a narrow op, 5 cycles for a wide op.
- Timeout: with no alu_done, err_timeout is high in cycle N+2+TIMEOUT and in_ready returns in the following cycle.
- If alu_done arrives in the same cycle the counter hits TIMEOUT, alu_done wins and no error is raised.

## Configuration
- ALU_SEQ_WIDE_WB_EN defined: wide ops take the two-beat WB_LO→WB_HI path described above.
- ALU_SEQ_WIDE_WB_EN undefined: WB_HI does not exist. Every op is single-beat with wb_last=1, result[127:64] is discarded, and is_wide_op() is not referenced.

## Structure
- The shared package (alongside opcode_t) holds:
  - the FSM state enum alu_seq_state_t
  - constant WIDE_OPS
  - function is_wide_op(opcode_t), which returns 1 for 10'h3A4 and 10'h3A5 (multiply-class extensions)
- Sub-module alu_seq_timeout: a loadable down-counter with clear/tick/expired. Everything else lives in alu_sequencer.
- Integration: alu_done connects to ALU exe_mem; alu_result and alu_flags connect to ALU result and flags.

## Test plan
- Reset then narrow op: in_opcode=10'h001, oprd1=5, oprd2=7, in_dst=3. The ALU model returns 12 one cycle after enable. Expect: alu_enable high exactly 1 cycle; wb beat with data=12, dst=3, wb_last=1 at accept+3; retired=1.
- Wide op (macro on): opcode 10'h3A4, model result 128'h1111_…_2222. Expect WB_LO data=low 64, wb_last=0, then WB_HI data=high 64, wb_last=1; retired increments once. With the macro off: a single beat with wb_last=1.
- Backpressure: hold wb_ready=0 for 5 cycles. Expect wb_valid and all wb_* stable, in_ready=0 throughout, acceptance only after the beat completes.
- Timeout with TIMEOUT=15 and alu_done never asserted. Expect err_timeout one cycle at accept+17, no wb_valid, retired unchanged, in_ready=1 next cycle. Also cover alu_done in the same cycle the counter hits TIMEOUT: a normal writeback, no error.
- Reset asserted in WAIT and again in WB_LO. Expect all outputs 0 and in_ready=1 the next cycle, no beat emitted, retired unchanged.
- Spurious alu_done in IDLE and ISSUE: no state change, no writeback.
